alu_result_buffer: RTL and testbench
====================================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter: width, 64, datapath width matching the upstream alu.
REQ-002 SHALL have parameter: tag_w, 5, destination-register tag width.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  upstream offers a result this cycle.
REQ-006 SHALL have port: in_ready  output  1  buffer accepts a result this cycle.
REQ-007 SHALL have port: in_data  input  width  alu out.
REQ-008 SHALL have ports: in_negative, in_zero, in_overflow  input  1 each  alu flags.
REQ-009 SHALL have port: in_tag  input  tag_w  destination tag.
REQ-010 SHALL have port: out_valid  output  1  head entry valid.
REQ-011 SHALL have port: out_ready  input  1  downstream consumes head.
REQ-012 SHALL have ports: out_data  output  width; out_negative, out_zero, out_overflow  output  1 each; out_tag  output  tag_w  head entry fields.
REQ-013 SHALL have port: flush  input  1  synchronous discard of all buffered entries.
REQ-014 SHALL have ports: trap  output  1; trap_tag  output  tag_w  overflow exception status.

Function
REQ-015 SHALL be a 2-entry FIFO skid buffer; states EMPTY, ONE, FULL.
REQ-016 Push SHALL occur when in_valid && in_ready; pop when out_valid && out_ready.
REQ-017 in_ready SHALL be a registered output, 1 in EMPTY/ONE, 0 in FULL (and 0 while trap=1 with the trap feature).
REQ-018 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE; FULL+pop->ONE; otherwise hold.
REQ-019 Latency SHALL be exactly 1 cycle: a result pushed at edge N is on out_* with out_valid=1 after edge N, fields unchanged.
REQ-020 Order SHALL be preserved; out_* SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 out_* fields SHALL be driven from registers; when out_valid=0 their value is don't-care but SHALL not be X after reset (zero).
REQ-022 flush=1 SHALL move state to EMPTY at the next edge, discarding entries; any push in that cycle SHALL be ignored; flush takes priority over push and pop.
REQ-023 Data, flags and tags SHALL pass bit-exact; no arithmetic is performed.

Reset
REQ-024 reset=1 SHALL immediately (asynchronously) force state EMPTY, in_ready=1, out_valid=0, out_* fields=0, trap=0, trap_tag=0.
REQ-025 Reset asserted mid-transfer SHALL drop all buffered entries; first push after release SHALL be accepted normally.

Configuration
REQ-026 Macro ALU_OVERFLOW_TRAP_EN SHALL select overflow trapping.
REQ-027 With ALU_OVERFLOW_TRAP_EN defined: a pushed entry with in_overflow=1 SHALL NOT be enqueued; trap SHALL go 1 after that edge with trap_tag=in_tag; trap SHALL be sticky until flush or reset; in_ready=0 while trap=1; entries already buffered SHALL still drain.
REQ-028 With ALU_OVERFLOW_TRAP_EN defined: out_overflow SHALL always read 0.
REQ-029 Without ALU_OVERFLOW_TRAP_EN: overflow entries SHALL be enqueued like any other, out_overflow SHALL carry in_overflow, trap and trap_tag SHALL be constant 0.
REQ-030 flush SHALL clear trap and trap_tag in the same edge it empties the buffer.

Verification
REQ-031 Single push in_data=3, tag=4, out_ready=1 -> out_valid=1 one cycle later, out_data=3, out_tag=4, then EMPTY.
REQ-032 out_ready=0, push 0x1 then 0x2 -> in_ready=0 after second edge (FULL); third offer 0x3 not accepted; release out_ready -> outputs 0x1, 0x2 in order, in_ready returns 1.
REQ-033 ONE state with simultaneous push 0xdeadbeef and pop -> stays ONE, out_data=0xdeadbeef next cycle.
REQ-034 FULL then flush=1 with in_valid=1 in_data=0x5 -> out_valid=0, state EMPTY, 0x5 never appears.
REQ-035 Trap build: push in_overflow=1 tag=7 -> trap=1, trap_tag=7, in_ready=0, no output; flush -> trap=0. Non-trap build: same push -> out_overflow=1, out_tag=7, trap=0.
REQ-036 Assert reset while FULL -> out_valid=0, in_ready=1, trap=0 immediately, before next clk edge.

Source files
------------

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: 2-entry FIFO skid buffer between the ALU and writeback.
// The head entry lives in the out_* registers; a second skid entry absorbs
// one extra result while downstream stalls. Optional overflow trapping is
// compiled in with the macro ALU_OVERFLOW_TRAP_EN: overflowing results are
// dropped, trap/trap_tag latch the tag, and intake stops until flush/reset.
module alu_result_buffer #(
    parameter int width = 64,
    parameter int tag_w = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    input  logic             in_negative,
    input  logic             in_zero,
    input  logic             in_overflow,
    input  logic [tag_w-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic             out_negative,
    output logic             out_zero,
    output logic             out_overflow,
    output logic [tag_w-1:0] out_tag,
    input  logic             flush,
    output logic             trap,
    output logic [tag_w-1:0] trap_tag
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic             push;
    logic             pop;
    logic             accept;
    logic             trap_n;

    logic [width-1:0] skid_data;
    logic             skid_negative;
    logic             skid_zero;
    logic             skid_overflow;
    logic [tag_w-1:0] skid_tag;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

`ifdef ALU_OVERFLOW_TRAP_EN
    logic trap_hit;

    // An overflowing result is never enqueued; it raises the trap instead.
    assign trap_hit = push && in_overflow;
    assign accept   = push && !in_overflow;
    assign trap_n   = flush ? 1'b0 : (trap || trap_hit);

    // Sticky trap status, cleared only by flush or reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap     <= 1'b0;
            trap_tag <= '0;
        end else if (flush) begin
            trap     <= 1'b0;
            trap_tag <= '0;
        end else if (trap_hit) begin
            trap     <= 1'b1;
            trap_tag <= in_tag;
        end
    end
`else
    assign accept   = push;
    assign trap_n   = 1'b0;
    assign trap     = 1'b0;
    assign trap_tag = '0;
`endif

    // Next-state selection; flush overrides any push or pop.
    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_n = ONE;
                ONE: begin
                    if (accept && !pop) state_n = FULL;
                    else if (!accept && pop) state_n = EMPTY;
                end
                FULL:  if (pop) state_n = ONE;
                default: state_n = EMPTY;
            endcase
        end
    end

    // State, registered handshakes and entry movement between skid and head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= EMPTY;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_negative  <= 1'b0;
            out_zero      <= 1'b0;
            out_overflow  <= 1'b0;
            out_tag       <= '0;
            skid_data     <= '0;
            skid_negative <= 1'b0;
            skid_zero     <= 1'b0;
            skid_overflow <= 1'b0;
            skid_tag      <= '0;
        end else begin
            state     <= state_n;
            in_ready  <= (state_n != FULL) && !trap_n;
            out_valid <= (state_n != EMPTY);
            if (!flush) begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            out_data     <= in_data;
                            out_negative <= in_negative;
                            out_zero     <= in_zero;
                            out_overflow <= in_overflow;
                            out_tag      <= in_tag;
                        end
                    end
                    ONE: begin
                        if (accept && pop) begin
                            out_data     <= in_data;
                            out_negative <= in_negative;
                            out_zero     <= in_zero;
                            out_overflow <= in_overflow;
                            out_tag      <= in_tag;
                        end else if (accept) begin
                            skid_data     <= in_data;
                            skid_negative <= in_negative;
                            skid_zero     <= in_zero;
                            skid_overflow <= in_overflow;
                            skid_tag      <= in_tag;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            out_data     <= skid_data;
                            out_negative <= skid_negative;
                            out_zero     <= skid_zero;
                            out_overflow <= skid_overflow;
                            out_tag      <= skid_tag;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer; expectations follow the
// ALU_OVERFLOW_TRAP_EN setting of the build.
module tb_alu_result_buffer;

`ifdef ALU_OVERFLOW_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_negative, in_zero, in_overflow;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_negative, out_zero, out_overflow;
    logic [4:0]  out_tag;
    logic        flush;
    logic        trap;
    logic [4:0]  trap_tag;

    int tests = 0;
    int fails = 0;

    alu_result_buffer #(.width(64), .tag_w(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_negative(in_negative), .in_zero(in_zero), .in_overflow(in_overflow),
        .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_negative(out_negative), .out_zero(out_zero), .out_overflow(out_overflow),
        .out_tag(out_tag),
        .flush(flush), .trap(trap), .trap_tag(trap_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [63:0] d;
        logic [4:0]  tag;
        logic        n, z, o;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic [63:0] e_d;
        logic [4:0]  e_tag;
        logic        e_n, e_z, e_o;
        logic        e_trap;
        logic [4:0]  e_ttag;
    } vec_t;

    vec_t v[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [63:0] d, input logic [4:0] tag,
                                input logic n, input logic z, input logic o,
                                input logic ordy, input logic fl,
                                input logic e_ov, input logic e_ir, input logic [63:0] e_d,
                                input logic [4:0] e_tag, input logic e_n, input logic e_z,
                                input logic e_o, input logic e_trap, input logic [4:0] e_ttag);
        vec_t r;
        r.iv = iv; r.d = d; r.tag = tag; r.n = n; r.z = z; r.o = o;
        r.ordy = ordy; r.fl = fl;
        r.e_ov = e_ov; r.e_ir = e_ir; r.e_d = e_d; r.e_tag = e_tag;
        r.e_n = e_n; r.e_z = e_z; r.e_o = e_o; r.e_trap = e_trap; r.e_ttag = e_ttag;
        return r;
    endfunction

    task automatic drive_idle();
        in_valid = 1'b0; in_data = '0; in_tag = '0;
        in_negative = 1'b0; in_zero = 1'b0; in_overflow = 1'b0;
        out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic push_one(input logic [63:0] d, input logic [4:0] tag, input logic o);
        @(negedge clk);
        drive_idle();
        in_valid = 1'b1; in_data = d; in_tag = tag; in_overflow = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // single push, pop next cycle
        v.push_back(mk(1, 64'h3, 5'd4, 0,0,0, 1, 0,  1,1, 64'h3, 5'd4, 0,0,0, 0,0));
        v.push_back(mk(0, 64'h0, 5'd0, 0,0,0, 1, 0,  0,1, 64'h0, 5'd0, 0,0,0, 0,0));
        // fill to FULL under backpressure, third offer refused, drain in order
        v.push_back(mk(1, 64'h1, 5'd1, 0,0,0, 0, 0,  1,1, 64'h1, 5'd1, 0,0,0, 0,0));
        v.push_back(mk(1, 64'h2, 5'd2, 0,0,0, 0, 0,  1,0, 64'h1, 5'd1, 0,0,0, 0,0));
        v.push_back(mk(1, 64'h3, 5'd3, 0,0,0, 0, 0,  1,0, 64'h1, 5'd1, 0,0,0, 0,0));
        v.push_back(mk(0, 64'h0, 5'd0, 0,0,0, 1, 0,  1,1, 64'h2, 5'd2, 0,0,0, 0,0));
        v.push_back(mk(0, 64'h0, 5'd0, 0,0,0, 1, 0,  0,1, 64'h0, 5'd0, 0,0,0, 0,0));
        // simultaneous push and pop in ONE
        v.push_back(mk(1, 64'h11, 5'd3, 0,0,0, 0, 0,  1,1, 64'h11, 5'd3, 0,0,0, 0,0));
        v.push_back(mk(1, 64'hdeadbeef, 5'd9, 0,0,0, 1, 0,  1,1, 64'hdeadbeef, 5'd9, 0,0,0, 0,0));
        v.push_back(mk(0, 64'h0, 5'd0, 0,0,0, 1, 0,  0,1, 64'h0, 5'd0, 0,0,0, 0,0));
        // FULL then flush with an offer present
        v.push_back(mk(1, 64'hA, 5'd1, 0,0,0, 0, 0,  1,1, 64'hA, 5'd1, 0,0,0, 0,0));
        v.push_back(mk(1, 64'hB, 5'd2, 0,0,0, 0, 0,  1,0, 64'hA, 5'd1, 0,0,0, 0,0));
        v.push_back(mk(1, 64'h5, 5'd5, 0,0,0, 0, 1,  0,1, 64'h0, 5'd0, 0,0,0, 0,0));
        v.push_back(mk(0, 64'h0, 5'd0, 0,0,0, 1, 0,  0,1, 64'h0, 5'd0, 0,0,0, 0,0));
        // flag and wide data pass-through
        v.push_back(mk(1, 64'hFFFF_0000_1234_5678, 5'd31, 1,0,0, 0, 0,
                       1,1, 64'hFFFF_0000_1234_5678, 5'd31, 1,0,0, 0,0));
        v.push_back(mk(1, 64'h0, 5'd0, 0,1,0, 1, 0,  1,1, 64'h0, 5'd0, 0,1,0, 0,0));
        v.push_back(mk(0, 64'h0, 5'd0, 0,0,0, 1, 0,  0,1, 64'h0, 5'd0, 0,0,0, 0,0));
        // overflow push: trapped or enqueued depending on build
        v.push_back(mk(1, 64'h77, 5'd7, 0,0,1, 0, 0,
                       !TRAP, !TRAP, 64'h77, 5'd7, 0,0,!TRAP, TRAP, TRAP ? 5'd7 : 5'd0));
        v.push_back(mk(1, 64'h99, 5'd8, 0,0,0, 0, 0,
                       !TRAP, 1'b0, 64'h77, 5'd7, 0,0,!TRAP, TRAP, TRAP ? 5'd7 : 5'd0));
        v.push_back(mk(0, 64'h0, 5'd0, 0,0,0, 0, 1,  0,1, 64'h0, 5'd0, 0,0,0, 0,0));
        v.push_back(mk(1, 64'h42, 5'd6, 0,0,0, 1, 0,  1,1, 64'h42, 5'd6, 0,0,0, 0,0));
        v.push_back(mk(0, 64'h0, 5'd0, 0,0,0, 1, 0,  0,1, 64'h0, 5'd0, 0,0,0, 0,0));

        drive_idle();
        reset = 1'b1;
        #2;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
        chk("reset_out_data",  out_data,           64'd0);
        chk("reset_out_tag",   {59'd0, out_tag},   64'd0);
        chk("reset_trap",      {63'd0, trap},      64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            in_valid = v[i].iv; in_data = v[i].d; in_tag = v[i].tag;
            in_negative = v[i].n; in_zero = v[i].z; in_overflow = v[i].o;
            out_ready = v[i].ordy; flush = v[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, v[i].e_ov});
            chk($sformatf("v%0d_in_ready", i),  {63'd0, in_ready},  {63'd0, v[i].e_ir});
            chk($sformatf("v%0d_trap", i),      {63'd0, trap},      {63'd0, v[i].e_trap});
            chk($sformatf("v%0d_trap_tag", i),  {59'd0, trap_tag},  {59'd0, v[i].e_ttag});
            if (v[i].e_ov) begin
                chk($sformatf("v%0d_out_data", i), out_data, v[i].e_d);
                chk($sformatf("v%0d_out_tag", i),  {59'd0, out_tag}, {59'd0, v[i].e_tag});
                chk($sformatf("v%0d_out_flags", i),
                    {61'd0, out_negative, out_zero, out_overflow},
                    {61'd0, v[i].e_n, v[i].e_z, v[i].e_o});
            end
        end

        // asynchronous reset while FULL, checked before the next clock edge
        push_one(64'h21, 5'd1, 1'b0);
        push_one(64'h22, 5'd2, 1'b0);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("async_rst_out_data",  out_data,           64'd0);
        chk("async_rst_trap",      {63'd0, trap},      64'd0);
        #1;
        reset = 1'b0;
        push_one(64'h55, 5'd12, 1'b0);
        chk("post_rst_out_valid", {63'd0, out_valid}, 64'd1);
        chk("post_rst_out_data",  out_data,           64'h55);
        chk("post_rst_out_tag",   {59'd0, out_tag},   64'd12);

        // reset also clears an overflow status mid-stream
        push_one(64'h66, 5'd13, 1'b1);
        chk("ovf_trap_set", {63'd0, trap}, {63'd0, TRAP});
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        #1;
        chk("rst_clears_trap",     {63'd0, trap},     64'd0);
        chk("rst_clears_trap_tag", {59'd0, trap_tag}, 64'd0);
        chk("rst_out_valid",       {63'd0, out_valid}, 64'd0);
        #1;
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
